led_driver: RTL and testbench
=============================

LED_DRIVER -- requirements
Module: led_driver

Interface
REQ-001 Parameter PWM_BITS, default 8: width of the brightness level and of the PWM counter.
REQ-002 Parameter BLINK_BITS, default 20: width of the blink timebase; one phase lasts 2^BLINK_BITS cycles.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_mode  input  2  00 OFF, 01 STEADY, 10 BLINK, 11 PULSE.
REQ-008 cmd_level  input  PWM_BITS  brightness duty, in units of 1/2^PWM_BITS.
REQ-009 cmd_count  input  4  number of pulses, used in PULSE mode only.
REQ-010 led  output  1  registered drive to the LED pin.
REQ-011 busy  output  1  high while a PULSE sequence is in progress.
REQ-012 done  output  1  one-cycle strobe when a PULSE sequence completes.

Function
REQ-013 A command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both 1; mode, level and count are captured at that edge.
REQ-014 cmd_ready SHALL equal NOT busy.
- Commands are accepted in OFF, STEADY and BLINK.
- Commands are ignored, not queued, during PULSE.
REQ-015 States SHALL be OFF, STEADY, BLINK, P_ON and P_OFF; busy SHALL be 1 exactly in P_ON and P_OFF.
REQ-016 PWM counter:
- Free-running PWM_BITS counter that wraps from all-ones to 0.
- Cleared to 0 on command acceptance.
- pwm_on = (pwm_ctr < level_q), unsigned compare.
- Level 0 gives always off; all-ones gives on for 2^PWM_BITS - 1 of every 2^PWM_BITS cycles.
REQ-017 Blink timebase:
- BLINK_BITS counter that wraps.
- tick = (counter == all-ones).
- Cleared to 0 on command acceptance.
REQ-018 Enable per state:
- OFF: 0.
- STEADY: 1.
- BLINK: phase.
- P_ON: 1.
- P_OFF: 0.
REQ-019 Phase SHALL be set to 1 on command acceptance and toggle on each tick while in BLINK.
REQ-020 led SHALL be registered: led <= pwm_on AND enable, evaluated from register values, so led reflects a command from the first edge after the accepting edge.
REQ-021 Command to state mapping:
- Mode 00 goes to OFF.
- Mode 01 goes to STEADY.
- Mode 10 goes to BLINK.
- Mode 11 with cmd_count > 0 goes to P_ON with remaining = cmd_count.
REQ-022 Mode 11 with cmd_count = 0 SHALL go to OFF and assert done for exactly the next cycle; busy stays 0.
REQ-023 PULSE sequencing:
- P_ON goes to P_OFF on tick.
- In P_OFF on tick, remaining is decremented.
- If remaining was 1, the state goes to OFF and done is 1 in the following cycle.
- Otherwise the state returns to P_ON.
REQ-024 The pulse sequence for count N SHALL last exactly N*2^(BLINK_BITS+1) cycles from the accepting edge to the edge that enters OFF.
REQ-025 A command accepted on the same edge as a tick SHALL take priority: counters clear and the new state applies; the tick is discarded.
REQ-026 cmd_level changes while not accepted SHALL have no effect.

Reset
REQ-027 On rst = 1, asynchronously:
- state = OFF; pwm_ctr, blink counter, remaining and level_q = 0; phase = 1.
- Outputs: led = 0, done = 0, busy = 0, cmd_ready = 1.
REQ-028 Reset asserted during PULSE SHALL abort the sequence with no done strobe.
REQ-029 The first command SHALL be accepted on the first rising edge after rst deasserts.

Verification (PWM_BITS=3, BLINK_BITS=4)
REQ-030 After reset, STEADY with level=3 -> led high 3 of every 8 cycles, starting the first edge after acceptance.
REQ-031 BLINK with level=7 -> 16-cycle phase with led at 7/8 duty, then 16 cycles with led = 0, repeating.
REQ-032 PULSE with count=2, level=7 -> busy high 64 cycles; cmd_ready = 0 and a STEADY command during this window is ignored; done is a single-cycle strobe the cycle after OFF is entered.
REQ-033 PULSE with count=0 -> done high exactly one cycle, busy never high, led stays 0.
REQ-034 rst pulsed mid-P_ON with count=3 -> led = 0 and busy = 0 immediately, no done strobe, cmd_ready = 1.
REQ-035 Command accepted on the tick edge during BLINK -> counters restart and the new mode timing is measured from that edge.

Source files
------------

// File: rtl/led_driver.sv
// PWM LED driver with OFF / STEADY / BLINK / PULSE modes.
// One command is taken per handshake; PULSE sequences block new commands until they finish.
module led_driver #(
    parameter int unsigned PWM_BITS   = 8,
    parameter int unsigned BLINK_BITS = 20
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_mode_i,
    input  logic [PWM_BITS-1:0] cmd_level_i,
    input  logic [3:0]          cmd_count_i,
    output logic                led_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic [2:0] {
        StOff,
        StSteady,
        StBlink,
        StPOn,
        StPOff
    } state_e;

    localparam logic [1:0] ModeOff    = 2'b00;
    localparam logic [1:0] ModeSteady = 2'b01;
    localparam logic [1:0] ModeBlink  = 2'b10;
    localparam logic [1:0] ModePulse  = 2'b11;

    state_e                state_q, state_d;
    logic [PWM_BITS-1:0]   pwm_ctr_q, pwm_ctr_d;
    logic [BLINK_BITS-1:0] blink_ctr_q, blink_ctr_d;
    logic [PWM_BITS-1:0]   level_q, level_d;
    logic [3:0]            remaining_q, remaining_d;
    logic                  phase_q, phase_d;
    logic                  led_q, led_d;
    logic                  done_q, done_d;

    logic busy;
    logic accept;
    logic tick;
    logic pwm_on;
    logic enable;

    assign busy        = (state_q == StPOn) || (state_q == StPOff);
    assign accept      = cmd_valid_i && !busy;
    assign tick        = &blink_ctr_q;
    assign pwm_on      = pwm_ctr_q < level_q;

    assign cmd_ready_o = !busy;
    assign busy_o      = busy;
    assign led_o       = led_q;
    assign done_o      = done_q;

    always_comb begin
        enable = 1'b0;
        unique case (state_q)
            StOff:    enable = 1'b0;
            StSteady: enable = 1'b1;
            StBlink:  enable = phase_q;
            StPOn:    enable = 1'b1;
            StPOff:   enable = 1'b0;
            default:  enable = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pwm_ctr_d   = pwm_ctr_q + 1'b1;
        blink_ctr_d = blink_ctr_q + 1'b1;
        level_d     = level_q;
        remaining_d = remaining_q;
        phase_d     = phase_q;
        done_d      = 1'b0;
        // led is computed from the pre-edge registers, so it trails a new command by one edge
        led_d       = pwm_on && enable;

        if (accept) begin
            // A command on a tick edge wins: counters restart and the tick is dropped
            pwm_ctr_d   = '0;
            blink_ctr_d = '0;
            phase_d     = 1'b1;
            level_d     = cmd_level_i;
            remaining_d = cmd_count_i;
            case (cmd_mode_i)
                ModeOff:    state_d = StOff;
                ModeSteady: state_d = StSteady;
                ModeBlink:  state_d = StBlink;
                ModePulse: begin
                    if (cmd_count_i != 4'd0) begin
                        state_d = StPOn;
                    end else begin
                        state_d = StOff;
                        done_d  = 1'b1;
                    end
                end
                default:    state_d = StOff;
            endcase
        end else if (tick) begin
            unique case (state_q)
                StBlink: phase_d = !phase_q;
                StPOn:   state_d = StPOff;
                StPOff: begin
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == 4'd1) begin
                        state_d = StOff;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StPOn;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StOff;
            pwm_ctr_q   <= '0;
            blink_ctr_q <= '0;
            level_q     <= '0;
            remaining_q <= '0;
            phase_q     <= 1'b1;
            led_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pwm_ctr_q   <= pwm_ctr_d;
            blink_ctr_q <= blink_ctr_d;
            level_q     <= level_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            led_q       <= led_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_led_driver.sv
// Bench for led_driver (PWM_BITS=3, BLINK_BITS=4): directed scenarios then random commands,
// compared each cycle against a time-since-command reference model.
module tb_led_driver;

    localparam int unsigned PwmBits   = 3;
    localparam int unsigned BlinkBits = 4;
    localparam int          Period    = 8;
    localparam int          Phase     = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_mode = 2'b00;
    logic [PwmBits-1:0] cmd_level = '0;
    logic [3:0]         cmd_count = 4'd0;
    logic               led;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: last accepted command plus cycles elapsed since its accepting edge
    int m_mode  = 0;
    int m_level = 0;
    int m_count = 0;
    int m_t     = 0;

    led_driver #(
        .PWM_BITS  (PwmBits),
        .BLINK_BITS(BlinkBits)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_mode_i (cmd_mode),
        .cmd_level_i(cmd_level),
        .cmd_count_i(cmd_count),
        .led_o      (led),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    function automatic logic model_busy();
        return (m_mode == 3) && (m_t < 2 * Phase * m_count);
    endfunction

    function automatic logic model_done();
        return (m_mode == 3) && (m_t == 2 * Phase * m_count);
    endfunction

    function automatic logic model_led();
        logic first_half;
        logic en;
        first_half = ((m_t / Phase) % 2) == 0;
        case (m_mode)
            0:       en = 1'b0;
            1:       en = 1'b1;
            2:       en = first_half;
            default: en = model_busy() && first_half;
        endcase
        return en && ((m_t % Period) < m_level);
    endfunction

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks = n_checks + 1;
        assert (got === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input logic v, input logic [1:0] m, input logic [PwmBits-1:0] lv,
                        input logic [3:0] c);
        logic exp_led;
        logic acc;
        cmd_valid = v;
        cmd_mode  = m;
        cmd_level = lv;
        cmd_count = c;
        exp_led   = model_led();
        acc       = v && !model_busy();
        @(posedge clk);
        if (acc) begin
            m_mode  = int'(m);
            m_level = int'(lv);
            m_count = int'(c);
            m_t     = 0;
        end else begin
            m_t = m_t + 1;
        end
        #1;
        check("led", led, exp_led);
        check("busy", busy, model_busy());
        check("ready", cmd_ready, !model_busy());
        check("done", done, model_done());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'($urandom_range(0, 3)),
                                         PwmBits'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_led", led, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        #2;
        rst     = 1'b0;
        m_mode  = 0;
        m_level = 0;
        m_count = 0;
        m_t     = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();

        // STEADY level 3, accepted on the first edge after reset release
        step(1'b1, 2'b01, 3'd3, 4'd0);
        idle(20);

        // BLINK level 7: 16 cycles at 7/8 duty, 16 cycles dark
        step(1'b1, 2'b10, 3'd7, 4'd0);
        idle(70);

        // PULSE count 2, with a STEADY request held the whole time
        step(1'b1, 2'b11, 3'd7, 4'd2);
        for (int i = 0; i < 66; i++) step(1'b1, 2'b01, 3'd2, 4'd0);
        idle(10);

        // PULSE count 0: immediate done, never busy
        step(1'b1, 2'b11, 3'd7, 4'd0);
        idle(6);

        // Reset in the middle of P_ON aborts the sequence
        step(1'b1, 2'b11, 3'd7, 4'd3);
        idle(8);
        pulse_reset();
        idle(4);

        // New command on the BLINK tick edge restarts the timing
        step(1'b1, 2'b10, 3'd5, 4'd0);
        idle(15);
        step(1'b1, 2'b10, 3'd6, 4'd0);
        idle(40);

        // Random traffic; unaccepted level/mode changes must be ignored
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                 PwmBits'($urandom_range(0, 7)), 4'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
